// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and helpers for the BRAM arbiter
package bram_arb_pkg;

  localparam int MAX_NREQ = 8;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Tag id is sized for the largest supported requester count.
  localparam int ID_W = clog2_min1(MAX_NREQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rsp_tag_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin select with lock override
module rr_pick
  import bram_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            lock_valid,
  input  logic [IW-1:0]   lock_id,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   winner,
  output logic            found
);

  int idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (lock_valid) begin
      // A held lock excludes everyone else, even if the owner is idle.
      found  = req[lock_id];
      winner = lock_id;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          found  = 1'b1;
          winner = IW'(idx);
        end
      end
    end
    if (found) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin sharing of one single-port BRAM
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 1408,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [DATA_W-1:0]        bram_data,
  output logic                     bram_we,
  output logic                     bram_re,
  input  logic [DATA_W-1:0]        bram_q
);

  localparam int IW = clog2_min1(NREQ);

  logic [IW-1:0]     rr_ptr;
  logic              lock_valid;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     win;
  logic              found;
  logic              xfer;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  rsp_tag_t          tags [RD_LAT];

  // While locked, rr_ptr already points at the owner, so it doubles as lock id.
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .lock_valid (lock_valid),
    .lock_id    (rr_ptr),
    .grant      (grant),
    .winner     (win),
    .found      (found)
  );

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer      = found & ~rst;
  assign req_ready = xfer ? grant : '0;
  assign bram_we   = xfer & req_we[win];
  assign bram_re   = xfer & ~req_we[win];
  assign bram_addr = xfer ? sel_addr : addr_sh;
  assign bram_data = xfer ? sel_data : data_sh;
  assign rsp_data  = bram_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      addr_sh    <= '0;
      data_sh    <= '0;
    end else begin
      if (xfer) begin
        addr_sh <= sel_addr;
        data_sh <= sel_data;
      end
      if (lock_valid) begin
        if (!req_valid[rr_ptr] || (xfer && !req_lock[rr_ptr])) begin
          lock_valid <= 1'b0;
          rr_ptr     <= next_idx(rr_ptr);
        end
      end else if (xfer) begin
        if (req_lock[win]) begin
          lock_valid <= 1'b1;
          rr_ptr     <= win;
        end else begin
          rr_ptr <= next_idx(win);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: bram_re, id: ID_W'(win)};
      for (int i = 1; i < RD_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  // Gated by rst so a read in flight at reset never surfaces.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tags[RD_LAT-1].id == ID_W'(i))
        rsp_valid[i] = tags[RD_LAT-1].valid & ~rst;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - bench for bram_arbiter at read latencies 1 and 2
module tb_bram_arbiter;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 1408;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_we    = '0;
  logic [NREQ-1:0]        req_lock  = '0;
  logic [NREQ*ADDR_W-1:0] req_addr  = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [DATA_W-1:0]      bram_q    = '0;

  logic [NREQ-1:0]   a_ready, a_rsp, b_ready, b_rsp;
  logic [DATA_W-1:0] a_rdata, a_bdata, b_rdata, b_bdata;
  logic [ADDR_W-1:0] a_baddr, b_baddr;
  logic              a_we, a_re, b_we, b_re;

  bram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_ready), .rsp_valid(a_rsp),
    .rsp_data(a_rdata), .bram_addr(a_baddr), .bram_data(a_bdata), .bram_we(a_we),
    .bram_re(a_re), .bram_q(bram_q)
  );

  bram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_ready), .rsp_valid(b_rsp),
    .rsp_data(b_rdata), .bram_addr(b_baddr), .bram_data(b_bdata), .bram_we(b_we),
    .bram_re(b_re), .bram_q(bram_q)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {int due; int id;} pend_t;
  pend_t pa[$];
  pend_t pb[$];

  int                m_ptr   = 0;
  bit                m_lk    = 1'b0;
  int                m_owner = 0;
  logic [ADDR_W-1:0] m_sh_a  = '0;
  logic [DATA_W-1:0] m_sh_d  = '0;
  int                cyc_n   = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs(low128)=%h exp(low128)=%h cycle=%0d", tag, obs[127:0], exp[127:0], cyc_n);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int i, input bit we, input bit lk, input logic [ADDR_W-1:0] a);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_lock[i]  = lk;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = rnd_data();
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    int                w;
    logic [NREQ-1:0]   er, ea, eb;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    bram_q = rnd_data();
    #3;
    w = -1;
    if (!rst) begin
      if (m_lk) begin
        if (req_valid[m_owner]) w = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
      end
    end
    er     = (w >= 0) ? NREQ'(1 << w) : '0;
    e_addr = (w >= 0) ? req_addr[w*ADDR_W +: ADDR_W] : m_sh_a;
    e_data = (w >= 0) ? req_wdata[w*DATA_W +: DATA_W] : m_sh_d;
    ea = '0;
    eb = '0;
    if (!rst) begin
      foreach (pa[i]) if (pa[i].due == cyc_n) ea[pa[i].id] = 1'b1;
      foreach (pb[i]) if (pb[i].due == cyc_n) eb[pb[i].id] = 1'b1;
    end
    chk("ready_lat1", DATA_W'(a_ready), DATA_W'(er));
    chk("ready_lat2", DATA_W'(b_ready), DATA_W'(er));
    chk("we_lat1", DATA_W'(a_we), DATA_W'(w >= 0 && req_we[w]));
    chk("we_lat2", DATA_W'(b_we), DATA_W'(w >= 0 && req_we[w]));
    chk("re_lat1", DATA_W'(a_re), DATA_W'(w >= 0 && !req_we[w]));
    chk("re_lat2", DATA_W'(b_re), DATA_W'(w >= 0 && !req_we[w]));
    chk("addr_lat1", DATA_W'(a_baddr), DATA_W'(e_addr));
    chk("addr_lat2", DATA_W'(b_baddr), DATA_W'(e_addr));
    chk("bdata_lat1", a_bdata, e_data);
    chk("bdata_lat2", b_bdata, e_data);
    chk("rsp_valid_lat1", DATA_W'(a_rsp), DATA_W'(ea));
    chk("rsp_valid_lat2", DATA_W'(b_rsp), DATA_W'(eb));
    chk("rsp_data_lat1", a_rdata, bram_q);
    chk("rsp_data_lat2", b_rdata, bram_q);
    @(posedge clk);
    if (rst) begin
      m_ptr  = 0;
      m_lk   = 1'b0;
      m_sh_a = '0;
      m_sh_d = '0;
      pa.delete();
      pb.delete();
    end else begin
      if (w >= 0) begin
        m_sh_a = e_addr;
        m_sh_d = e_data;
        if (!req_we[w]) begin
          pa.push_back('{due: cyc_n + 1, id: w});
          pb.push_back('{due: cyc_n + 2, id: w});
        end
      end
      if (m_lk) begin
        if (!req_valid[m_owner] || (w == m_owner && !req_lock[m_owner])) begin
          m_lk  = 1'b0;
          m_ptr = (m_owner + 1) % NREQ;
        end
      end else if (w >= 0) begin
        if (req_lock[w]) begin
          m_lk    = 1'b1;
          m_owner = w;
          m_ptr   = w;
        end else begin
          m_ptr = (w + 1) % NREQ;
        end
      end
      for (int i = pa.size() - 1; i >= 0; i--) if (pa[i].due <= cyc_n) pa.delete(i);
      for (int i = pb.size() - 1; i >= 0; i--) if (pb[i].due <= cyc_n) pb.delete(i);
    end
    cyc_n++;
    #1;
  endtask

  task automatic do_reset();
    clr_req();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '1;
    cyc();
    cyc();
    rst = 1'b0;
    clr_req();
    cyc();

    set_req(1, 1'b0, 1'b0, 10'h055);
    cyc();
    clr_req();
    cyc();
    cyc();

    do_reset();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, n[0], 1'b0, ADDR_W'($urandom));
      cyc();
    end

    do_reset();
    for (int n = 0; n < 6; n++) begin
      clr_req();
      if (n < 4) set_req(0, 1'b1, n < 3, ADDR_W'(n + 16));
      set_req(1, 1'b0, 1'b0, 10'h101);
      set_req(2, 1'b0, 1'b0, 10'h202);
      cyc();
    end

    do_reset();
    set_req(2, 1'b0, 1'b0, 10'h3a0);
    cyc();
    clr_req();
    set_req(0, 1'b1, 1'b0, 10'h3a0);
    cyc();
    clr_req();
    repeat (3) cyc();

    do_reset();
    set_req(1, 1'b0, 1'b0, 10'h077);
    cyc();
    clr_req();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    set_req(1, 1'b0, 1'b0, 10'h011);
    set_req(2, 1'b0, 1'b0, 10'h022);
    cyc();
    clr_req();
    repeat (3) cyc();

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      clr_req();
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) != 0)
          set_req(i, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, ADDR_W'($urandom));
      end
      cyc();
    end
    rst = 1'b0;
    clr_req();
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
